// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

   // Money is carried as unsigned cents in a fixed-width register
   localparam int unsigned CREDIT_W    = 16;
   // Width of the stock count returned by the item store
   localparam int unsigned ITEM_DATA_W = 8;

   localparam logic [1:0] ERR_INVALID_SEL = 2'b01;
   localparam logic [1:0] ERR_SOLD_OUT    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT_DATA,
      ST_CHECK,
      ST_COLLECT,
      ST_DISPENSE,
      ST_CHANGE
   } vend_state_t;

   // Add two credit values, clamping at the all-ones maximum
   function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
   endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: saturating coin accumulation, sale subtraction and clear.
module vend_credit_acc
   import vend_pkg::*;
(
   input  logic                clk_fsm,
   input  logic                rst,
   input  logic                clr,
   input  logic                add_en,
   input  logic [CREDIT_W-1:0] add_val,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] sub_val,
   output logic [CREDIT_W-1:0] credit
);

   // Clear wins over subtract, subtract over add; the controller never asserts them together
   always_ff @(posedge clk_fsm or posedge rst) begin
      if (rst) begin
         credit <= '0;
      end else if (clr) begin
         credit <= '0;
      end else if (sub_en) begin
         credit <= credit - sub_val;
      end else if (add_en) begin
         credit <= sat_add(credit, add_val);
      end
   end

endmodule

// File: rtl/vend_txn_fsm.sv
// Vending transaction controller: selection, store lookup, coin collection,
// dispense, change and stock commit.
// Optional build macro VEND_TIMEOUT_EN enables the COLLECT inactivity refund.
module vend_txn_fsm
   import vend_pkg::*;
#(
   parameter int unsigned MAX_ITEMS      = 1024,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   clk_fsm,
   input  logic                   rst,
   input  logic                   sel_valid,
   input  logic [ADDR_WIDTH-1:0]  sel_item,
   input  logic                   coin_valid,
   input  logic [CREDIT_W-1:0]    coin_value,
   output logic                   coin_ready,
   input  logic                   cancel,
   output logic                   fsm_read_en,
   output logic [ADDR_WIDTH-1:0]  fsm_read_addr,
   input  logic [CREDIT_W-1:0]    fsm_item_cost,
   input  logic [ITEM_DATA_W-1:0] fsm_item_available,
   input  logic                   fsm_data_valid,
   output logic                   fsm_update_en,
   output logic [ADDR_WIDTH-1:0]  fsm_update_addr,
   output logic                   dispense_valid,
   output logic [ADDR_WIDTH-1:0]  dispense_item,
   output logic                   change_valid,
   output logic [CREDIT_W-1:0]    change_amount,
   output logic                   err_valid,
   output logic [1:0]             err_code,
   output logic                   busy
);

   vend_state_t           state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CREDIT_W-1:0]   cost_q;
   logic                  sold_out_q;
   logic [CREDIT_W-1:0]   credit;
   logic                  coin_acc;
   logic                  sel_ok;
   logic                  tmo_hit;

   // coin_ready is a registered mirror of "state is IDLE or COLLECT"
   assign coin_acc = coin_valid && coin_ready;
   assign sel_ok   = 32'(sel_item) < MAX_ITEMS;

   vend_credit_acc u_credit (
      .clk_fsm (clk_fsm),
      .rst     (rst),
      .clr     (state == ST_CHANGE),
      .add_en  (coin_acc),
      .add_val (coin_value),
      .sub_en  (state == ST_DISPENSE),
      .sub_val (cost_q),
      .credit  (credit)
   );

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive COLLECT cycle without an accepted coin
   assign tmo_hit = (state == ST_COLLECT) && !coin_acc &&
                    (32'(tmo_cnt) == TIMEOUT_CYCLES - 1);

   // Inactivity counter: runs only in COLLECT, restarts on every accepted coin
   always_ff @(posedge clk_fsm or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state != ST_COLLECT || coin_acc) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo_hit        = 1'b0;
`endif

   // Transaction sequencer; outputs are registered alongside the state they belong to
   always_ff @(posedge clk_fsm or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         addr_q          <= '0;
         cost_q          <= '0;
         sold_out_q      <= 1'b0;
         coin_ready      <= 1'b0;
         fsm_read_en     <= 1'b0;
         fsm_read_addr   <= '0;
         fsm_update_en   <= 1'b0;
         fsm_update_addr <= '0;
         dispense_valid  <= 1'b0;
         dispense_item   <= '0;
         change_valid    <= 1'b0;
         change_amount   <= '0;
         err_valid       <= 1'b0;
         err_code        <= '0;
         busy            <= 1'b0;
      end else begin
         fsm_read_en    <= 1'b0;
         fsm_update_en  <= 1'b0;
         dispense_valid <= 1'b0;
         change_valid   <= 1'b0;
         err_valid      <= 1'b0;

         case (state)
            ST_IDLE: begin
               coin_ready <= 1'b1;
               busy       <= 1'b0;
               if (sel_valid) begin
                  if (sel_ok) begin
                     addr_q     <= sel_item;
                     state      <= ST_READ;
                     coin_ready <= 1'b0;
                     busy       <= 1'b1;
                  end else begin
                     err_valid <= 1'b1;
                     err_code  <= ERR_INVALID_SEL;
                  end
               end
            end

            ST_READ: begin
               fsm_read_en   <= 1'b1;
               fsm_read_addr <= addr_q;
               state         <= ST_WAIT_DATA;
            end

            ST_WAIT_DATA: begin
               if (fsm_data_valid) begin
                  cost_q     <= fsm_item_cost;
                  sold_out_q <= (fsm_item_available == '0);
                  state      <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (sold_out_q) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_SOLD_OUT;
                  state     <= ST_CHANGE;
               end else if (credit >= cost_q) begin
                  dispense_valid  <= 1'b1;
                  dispense_item   <= addr_q;
                  fsm_update_en   <= 1'b1;
                  fsm_update_addr <= addr_q;
                  state           <= ST_DISPENSE;
               end else begin
                  coin_ready <= 1'b1;
                  state      <= ST_COLLECT;
               end
            end

            ST_COLLECT: begin
               // A coin accepted on the leaving cycle is already in credit by CHANGE
               if (cancel) begin
                  coin_ready <= 1'b0;
                  state      <= ST_CHANGE;
               end else if (tmo_hit) begin
                  err_valid  <= 1'b1;
                  err_code   <= ERR_TIMEOUT;
                  coin_ready <= 1'b0;
                  state      <= ST_CHANGE;
               end else if (credit >= cost_q) begin
                  dispense_valid  <= 1'b1;
                  dispense_item   <= addr_q;
                  fsm_update_en   <= 1'b1;
                  fsm_update_addr <= addr_q;
                  coin_ready      <= 1'b0;
                  state           <= ST_DISPENSE;
               end
            end

            ST_DISPENSE: begin
               state <= ST_CHANGE;
            end

            ST_CHANGE: begin
               if (credit != '0) begin
                  change_valid  <= 1'b1;
                  change_amount <= credit;
               end
               coin_ready <= 1'b1;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end

            default: begin
               coin_ready <= 1'b1;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_txn_fsm.sv
// Directed self-checking bench for vend_txn_fsm with a one-cycle-latency item store.
// Build with VEND_TIMEOUT_EN defined to exercise the inactivity refund.
`timescale 1ns/1ps
module tb_vend_txn_fsm;

   localparam int unsigned AW = 11;

   logic          clk_fsm = 1'b0;
   logic          rst = 1'b1;
   logic          sel_valid = 1'b0;
   logic [AW-1:0] sel_item = '0;
   logic          coin_valid = 1'b0;
   logic [15:0]   coin_value = '0;
   logic          coin_ready;
   logic          cancel = 1'b0;
   logic          fsm_read_en;
   logic [AW-1:0] fsm_read_addr;
   logic [15:0]   st_cost = '0;
   logic [7:0]    st_avail = '0;
   logic          st_valid = 1'b0;
   logic          fsm_update_en;
   logic [AW-1:0] fsm_update_addr;
   logic          dispense_valid;
   logic [AW-1:0] dispense_item;
   logic          change_valid;
   logic [15:0]   change_amount;
   logic          err_valid;
   logic [1:0]    err_code;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   vend_txn_fsm #(
      .MAX_ITEMS      (1024),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_fsm            (clk_fsm),
      .rst                (rst),
      .sel_valid          (sel_valid),
      .sel_item           (sel_item),
      .coin_valid         (coin_valid),
      .coin_value         (coin_value),
      .coin_ready         (coin_ready),
      .cancel             (cancel),
      .fsm_read_en        (fsm_read_en),
      .fsm_read_addr      (fsm_read_addr),
      .fsm_item_cost      (st_cost),
      .fsm_item_available (st_avail),
      .fsm_data_valid     (st_valid),
      .fsm_update_en      (fsm_update_en),
      .fsm_update_addr    (fsm_update_addr),
      .dispense_valid     (dispense_valid),
      .dispense_item      (dispense_item),
      .change_valid       (change_valid),
      .change_amount      (change_amount),
      .err_valid          (err_valid),
      .err_code           (err_code),
      .busy               (busy)
   );

   always #5 clk_fsm = ~clk_fsm;

   // Item table: cost and initial stock per slot
   function automatic logic [15:0] item_cost(input logic [AW-1:0] a);
      case (a)
         11'd5:   return 16'd150;
         11'd7:   return 16'd100;
         11'd9:   return 16'd300;
         default: return 16'd50;
      endcase
   endfunction

   function automatic logic [7:0] item_stock(input logic [AW-1:0] a);
      case (a)
         11'd5:   return 8'd3;
         11'd7:   return 8'd0;
         default: return 8'd5;
      endcase
   endfunction

   int sold [0:2047];
   int cyc = 0;

   // Store model: data one cycle after the read strobe, stock drops per commit
   always @(posedge clk_fsm) begin
      cyc      <= cyc + 1;
      st_valid <= fsm_read_en;
      if (fsm_read_en) begin
         st_cost  <= item_cost(fsm_read_addr);
         st_avail <= item_stock(fsm_read_addr) - 8'(sold[fsm_read_addr]);
      end
      if (fsm_update_en) sold[fsm_update_addr] <= sold[fsm_update_addr] + 1;
   end

   // Pulse monitor
   int n_disp = 0, n_upd = 0, n_chg = 0, n_err = 0, n_read = 0;
   logic [AW-1:0] last_disp = '0, last_upd = '0;
   logic [15:0]   last_chg = '0;
   logic [1:0]    last_err = '0;
   int            disp_cyc = 0;

   always @(negedge clk_fsm) begin
      if (dispense_valid) begin
         n_disp    <= n_disp + 1;
         last_disp <= dispense_item;
         disp_cyc  <= cyc;
      end
      if (fsm_update_en) begin
         n_upd    <= n_upd + 1;
         last_upd <= fsm_update_addr;
      end
      if (change_valid) begin
         n_chg    <= n_chg + 1;
         last_chg <= change_amount;
      end
      if (err_valid) begin
         n_err    <= n_err + 1;
         last_err <= err_code;
      end
      if (fsm_read_en) n_read <= n_read + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_fsm);
         #1;
      end
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 30 && !coin_ready; i++) tick(1);
      chk(tag, 32'(coin_ready), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 30 && busy; i++) tick(1);
      chk(tag, 32'(busy), 32'd0);
      tick(2);
   endtask

   task automatic coin(input logic [15:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      tick(1);
      coin_valid = 1'b0;
   endtask

   int sel_cyc;
   task automatic sel(input logic [AW-1:0] i);
      sel_valid = 1'b1;
      sel_item  = i;
      sel_cyc   = cyc;
      tick(1);
      sel_valid = 1'b0;
   endtask

   int b_disp, b_upd, b_chg, b_err, b_read;
   task automatic snap();
      b_disp = n_disp; b_upd = n_upd; b_chg = n_chg; b_err = n_err; b_read = n_read;
   endtask

   initial begin
      // Reset
      tick(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_coin_ready", 32'(coin_ready), 32'd0);
      chk("rst_read_en", 32'(fsm_read_en), 32'd0);
      rst = 1'b0;
      tick(1);
      chk("idle_coin_ready", 32'(coin_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // 1: prepaid 200, item 5 cost 150 -> dispense, commit, change 50
      snap();
      coin(16'd100);
      coin(16'd100);
      sel(11'd5);
      wait_idle("t1_idle");
      chk("t1_latency", 32'(disp_cyc - sel_cyc), 32'd5);
      chk("t1_disp_n", 32'(n_disp - b_disp), 32'd1);
      chk("t1_disp_item", 32'(last_disp), 32'd5);
      chk("t1_upd_n", 32'(n_upd - b_upd), 32'd1);
      chk("t1_upd_addr", 32'(last_upd), 32'd5);
      chk("t1_chg_n", 32'(n_chg - b_chg), 32'd1);
      chk("t1_chg_amt", 32'(last_chg), 32'd50);
      chk("t1_read_n", 32'(n_read - b_read), 32'd1);
      chk("t1_sold", 32'(sold[5]), 32'd1);

      // 1b: same item paid during COLLECT
      snap();
      sel(11'd5);
      wait_ready("t1b_collect");
      coin(16'd100);
      coin(16'd100);
      wait_idle("t1b_idle");
      chk("t1b_disp_n", 32'(n_disp - b_disp), 32'd1);
      chk("t1b_chg_amt", 32'(last_chg), 32'd50);
      chk("t1b_sold", 32'(sold[5]), 32'd2);

      // 2: sold out with prepaid credit -> err 10, full refund, no commit
      snap();
      coin(16'd200);
      sel(11'd7);
      wait_idle("t2_idle");
      chk("t2_err_n", 32'(n_err - b_err), 32'd1);
      chk("t2_err_code", 32'(last_err), 32'd2);
      chk("t2_chg_amt", 32'(last_chg), 32'd200);
      chk("t2_chg_n", 32'(n_chg - b_chg), 32'd1);
      chk("t2_upd_n", 32'(n_upd - b_upd), 32'd0);
      chk("t2_disp_n", 32'(n_disp - b_disp), 32'd0);

      // 3: out-of-range selection
      snap();
      sel(11'd1024);
      chk("t3_err_valid", 32'(err_valid), 32'd1);
      chk("t3_err_code", 32'(err_code), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      tick(3);
      chk("t3_busy_later", 32'(busy), 32'd0);
      chk("t3_read_n", 32'(n_read - b_read), 32'd0);

      // 4: cancel together with a coin -> refund includes that coin
      snap();
      sel(11'd9);
      wait_ready("t4_collect");
      coin(16'd100);
      coin_valid = 1'b1;
      coin_value = 16'd50;
      cancel     = 1'b1;
      tick(1);
      coin_valid = 1'b0;
      cancel     = 1'b0;
      wait_idle("t4_idle");
      chk("t4_chg_amt", 32'(last_chg), 32'd150);
      chk("t4_chg_n", 32'(n_chg - b_chg), 32'd1);
      chk("t4_disp_n", 32'(n_disp - b_disp), 32'd0);
      chk("t4_upd_n", 32'(n_upd - b_upd), 32'd0);

      // 5: inactivity in COLLECT
      snap();
      sel(11'd9);
      wait_ready("t5_collect");
      coin(16'd100);
`ifdef VEND_TIMEOUT_EN
      begin
         int k;
         k = 0;
         for (int i = 1; i <= 40; i++) begin
            tick(1);
            k = i;
            if (err_valid) break;
         end
         chk("t5_tmo_cycles", 32'(k), 32'd16);
         chk("t5_err_code", 32'(err_code), 32'd3);
      end
      wait_idle("t5_idle");
`else
      tick(1000);
      chk("t5_still_busy", 32'(busy), 32'd1);
      chk("t5_still_collect", 32'(coin_ready), 32'd1);
      chk("t5_no_err", 32'(n_err - b_err), 32'd0);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      wait_idle("t5_idle");
`endif
      chk("t5_chg_amt", 32'(last_chg), 32'd100);
      chk("t5_chg_n", 32'(n_chg - b_chg), 32'd1);
      chk("t5_disp_n", 32'(n_disp - b_disp), 32'd0);

      // 6a: saturating credit, refunded through a sold-out selection
      snap();
      coin(16'hFFF0);
      coin(16'h0100);
      sel(11'd7);
      wait_idle("t6_idle");
      chk("t6_sat_chg", 32'(last_chg), 32'h0000FFFF);
      chk("t6_err_code", 32'(last_err), 32'd2);

      // 6b: reset in the middle of COLLECT
      snap();
      sel(11'd9);
      wait_ready("t6_collect");
      coin(16'd100);
      tick(2);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_coin_ready", 32'(coin_ready), 32'd0);
      chk("t6_rst_err_code", 32'(err_code), 32'd0);
      chk("t6_rst_chg_amt", 32'(change_amount), 32'd0);
      chk("t6_rst_disp_item", 32'(dispense_item), 32'd0);
      chk("t6_rst_upd_addr", 32'(fsm_update_addr), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(5);
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_chg_n", 32'(n_chg - b_chg), 32'd0);
      // Credit must have been discarded: a sold-out pick refunds nothing
      sel(11'd7);
      wait_idle("t6_post_idle");
      chk("t6_post_err_code", 32'(last_err), 32'd2);
      chk("t6_post_no_refund", 32'(n_chg - b_chg), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
